ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
AHB-Lite subordinate (responder) backed by a word-addressed memory array. It decodes a selected address phase and inserts a programmable number of wait states. It then completes the data phase with read data or a write commit, or with a two-cycle ERROR response. Its HREADYOUT/HRESP/HRDATA outputs feed one slave leg (HREADYn/HRESPn/HRDATAn) of the response multiplexer; its HREADY input is the multiplexed bus HREADY.

Parameters:
ADDR_WIDTH, 32, width of HADDR
DATA_WIDTH, 32, width of HWDATA/HRDATA (32 or 64)
MEM_DEPTH, 256, number of DATA_WIDTH words in the array
WAIT_STATES, 1, HREADYOUT-low cycles inserted per OKAY transfer (0..15)

Ports:
HCLK  in  1  bus clock; all state updates on rising edge
HRESETn  in  1  synchronous active-low reset
HSEL  in  1  slave select from address decoder (address phase)
HADDR  in  ADDR_WIDTH  byte address (address phase)
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size, bytes = 2^HSIZE
HBURST  in  3  accepted, not used for decode
HWDATA  in  DATA_WIDTH  write data (data phase)
HREADY  in  1  bus HREADY from response mux
HREADYOUT  out  1  slave ready
HRESP  out  2  00 OKAY, 01 ERROR
HRDATA  out  DATA_WIDTH  read data

Behaviour:
- Clock HCLK, reset HRESETn: one clock; reset is synchronous and active-low.
- Reset (HRESETn=0 at a rising edge): state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, latched transfer discarded. An in-flight write is not committed. Memory contents are not cleared.
- Transfer accept: at a rising edge with HSEL=1 && HREADY=1 && HTRANS[1]=1, latch HADDR, HWRITE and HSIZE. Then evaluate the error condition.
- No accept (HSEL=0, HTRANS IDLE/BUSY, or HREADY=0): the next data phase is zero-wait OKAY, with HREADYOUT=1 and HRESP=00.
- Error condition, any of:
  - word index (HADDR / (DATA_WIDTH/8)) >= MEM_DEPTH
  - 2^HSIZE > DATA_WIDTH/8
  - HADDR not aligned to 2^HSIZE
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=00. Accept OK with WAIT_STATES>0 -> WAIT (counter loaded with WAIT_STATES-1). Accept OK with WAIT_STATES=0 -> LAST. Accept with error -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=00. Counter decrements each cycle; at 0 -> LAST.
  - LAST: HREADYOUT=1, HRESP=00. Reads drive HRDATA = mem[index]. Writes commit HWDATA byte lanes selected by HSIZE and HADDR low bits (little-endian) at the closing edge. A new accept on the same edge goes to WAIT/LAST/ERR1 as above; otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=01 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. The write is discarded. A new accept on the same edge is honoured; otherwise -> IDLE.
- HRDATA = 0 in every state except LAST-read. HRDATA is held stable for the whole LAST cycle.
- Read-after-write to the same word in back-to-back transfers returns the new data, including with WAIT_STATES=0. This requires forwarding the committing write to the read path.
- Latency: an OKAY transfer occupies the data phase for WAIT_STATES+1 cycles. An ERROR transfer occupies exactly 2 cycles.
- Address-phase inputs are ignored while HREADY=0. The master holds them; the slave does not re-sample.
- Sub-word reads return the full addressed word; the master selects lanes.

Test Plan:
- Reset: hold HRESETn=0 for 2 edges mid-WAIT of a write to 0x10 -> HREADYOUT=1, HRESP=00, HRDATA=0; a later read of 0x10 returns its pre-write value.
- Write then read, WAIT_STATES=1: NONSEQ write word 0x20 = 0xDEADBEEF, then NONSEQ read 0x20 -> each data phase has 1 cycle of HREADYOUT=0; the read LAST cycle shows HRDATA=0xDEADBEEF, HRESP=00.
- Byte lanes: write HSIZE=0 to 0x21 with HWDATA=0x0000AB00, then word read 0x20 -> 0xDEADABEF.
- Out of range, MEM_DEPTH=256: read 0x400 -> cycle 1 HREADYOUT=0/HRESP=01, cycle 2 HREADYOUT=1/HRESP=01, HRDATA=0; misaligned word write to 0x22 -> same 2-cycle ERROR and memory unchanged.
- Pipelined, WAIT_STATES=0: write 0x30=0x11111111 immediately followed by read 0x30 -> read returns 0x11111111 with no wait cycles.
- IDLE/BUSY and HSEL=0 transfers -> HREADYOUT=1, HRESP=00 on every cycle; memory is not modified.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// AHB-Lite subordinate backed by a word-addressed memory array. It inserts a fixed number of
// wait states per OKAY transfer and gives a two-cycle ERROR for bad address, size or alignment.
module ahb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt_q, cnt_nxt;
    logic [IDX_W-1:0]      idx_q;
    logic [LSB-1:0]        off_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_nxt;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  req_err;
    logic [IDX_W-1:0]      haddr_idx;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_read;
    logic                  fwd;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_inputs;

    assign unused_inputs = ^{HBURST, HTRANS[0]};

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [LSB-1:0] off,
                                                        input logic [2:0] size);
        logic [DATA_WIDTH-1:0] m;
        int lo;
        int n;
        m  = '0;
        lo = int'(off);
        n  = 1 << size;
        for (int i = 0; i < NBYTES; i++) begin
            if (i >= lo && i < lo + n) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Handshake: an address phase is taken only when HSEL, a NONSEQ/SEQ HTRANS and the bus
    // HREADY are all high at the rising edge, and only from a state whose data phase is closing.
    assign accept = HSEL && HREADY && HTRANS[1] &&
                    (state == S_IDLE || state == S_LAST || state == S_ERR2);

    assign haddr_idx  = HADDR[LSB +: IDX_W];
    assign align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
    assign req_err    = ((HADDR >> LSB) >= ADDR_WIDTH'(MEM_DEPTH)) ||
                        (int'(HSIZE) > LSB) ||
                        ((HADDR & align_mask) != '0);

    assign wmask     = lane_mask(off_q, size_q);
    assign wr_merged = (mem[idx_q] & ~wmask) | (HWDATA & wmask);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        case (state)
            S_IDLE, S_LAST, S_ERR2: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (req_err) begin
                        state_nxt = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        state_nxt = S_LAST;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_nxt = S_LAST;
                else               cnt_nxt   = cnt_q - 4'd1;
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read data is registered on entry to LAST; a write closing on that same edge is merged in
    // so back-to-back read-after-write sees the new word even with zero wait states.
    always_comb begin
        rd_idx    = (state == S_WAIT) ? idx_q : haddr_idx;
        rd_read   = (state == S_WAIT) ? !write_q : !HWRITE;
        fwd       = (state == S_LAST) && write_q && (idx_q == rd_idx);
        rd_word   = fwd ? wr_merged : mem[rd_idx];
        rdata_nxt = '0;
        if (state_nxt == S_LAST && rd_read) rdata_nxt = rd_word;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            off_q   <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt_q   <= cnt_nxt;
            rdata_q <= rdata_nxt;
            if (accept) begin
                idx_q   <= haddr_idx;
                off_q   <= HADDR[LSB-1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
        end
    end

    // Contents survive reset; only a write reaching LAST outside reset is committed.
    always_ff @(posedge HCLK) begin
        if (HRESETn && state == S_LAST && write_q) mem[idx_q] <= wr_merged;
    end

    assign HREADYOUT = !(state == S_WAIT || state == S_ERR1);
    assign HRESP     = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;
    assign HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench: one instance with one wait state, one with none, each on its own bus leg
// whose HREADY is looped back from its own HREADYOUT.
module tb_ahb_slave_mem;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hsel1, hsel0;
    logic        hready1, hready0;
    logic        hreadyout1, hreadyout0;
    logic [1:0]  hresp1, hresp0;
    logic [31:0] hrdata1, hrdata0;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    assign hready1 = hreadyout1;
    assign hready0 = hreadyout0;

    ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1)) u_ws1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HREADY(hready1),
        .HREADYOUT(hreadyout1), .HRESP(hresp1), .HRDATA(hrdata1)
    );

    ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HREADY(hready0),
        .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0)
    );

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic rdy, input logic [1:0] resp,
                        input logic [31:0] rdata, input logic erdy, input logic [1:0] eresp,
                        input logic [31:0] erdata);
        chk({tag, "_ready"}, 32'(rdy), 32'(erdy));
        chk({tag, "_resp"}, 32'(resp), 32'(eresp));
        chk({tag, "_rdata"}, rdata, erdata);
    endtask

    task automatic drive_addr(input logic [31:0] a, input logic [1:0] tr, input logic wr,
                              input logic [2:0] sz);
        haddr  = a;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
    endtask

    // One isolated transfer on the one-wait-state instance, checking every data-phase cycle.
    task automatic xfer1(input string tag, input logic [31:0] a, input logic wr,
                         input logic [2:0] sz, input logic [31:0] wd, input logic err,
                         input logic [31:0] rexp);
        hsel1 = 1'b1;
        drive_addr(a, 2'b10, wr, sz);
        tick;
        hsel1  = 1'b0;
        htrans = 2'b00;
        hwdata = wd;
        chk1({tag, "_c1"}, hreadyout1, hresp1, hrdata1, 1'b0, err ? 2'b01 : 2'b00, 32'h0);
        tick;
        chk1({tag, "_c2"}, hreadyout1, hresp1, hrdata1, 1'b1, err ? 2'b01 : 2'b00,
             (!wr && !err) ? rexp : 32'h0);
        tick;
        chk1({tag, "_idle"}, hreadyout1, hresp1, hrdata1, 1'b1, 2'b00, 32'h0);
    endtask

    initial begin
        HRESETn = 1'b0;
        hsel1   = 1'b0;
        hsel0   = 1'b0;
        hwdata  = 32'h0;
        drive_addr(32'h0, 2'b00, 1'b0, 3'd2);
        tick;
        tick;
        chk1("rst_ws1", hreadyout1, hresp1, hrdata1, 1'b1, 2'b00, 32'h0);
        chk1("rst_ws0", hreadyout0, hresp0, hrdata0, 1'b1, 2'b00, 32'h0);
        HRESETn = 1'b1;
        tick;

        xfer1("wr10", 32'h10, 1'b1, 3'd2, 32'hCAFE0010, 1'b0, 32'h0);

        // Write to 0x10 aborted by reset while in its wait state.
        hsel1 = 1'b1;
        drive_addr(32'h10, 2'b10, 1'b1, 3'd2);
        tick;
        hsel1  = 1'b0;
        htrans = 2'b00;
        hwdata = 32'h12345678;
        chk1("abort_wait", hreadyout1, hresp1, hrdata1, 1'b0, 2'b00, 32'h0);
        HRESETn = 1'b0;
        tick;
        tick;
        chk1("abort_rst", hreadyout1, hresp1, hrdata1, 1'b1, 2'b00, 32'h0);
        HRESETn = 1'b1;
        tick;
        xfer1("rd10", 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hCAFE0010);

        xfer1("wr20", 32'h20, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
        xfer1("rd20", 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);
        xfer1("wrb21", 32'h21, 1'b1, 3'd0, 32'h0000AB00, 1'b0, 32'h0);
        xfer1("rd20_b", 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEADABEF);
        xfer1("wrh22", 32'h22, 1'b1, 3'd1, 32'h55660000, 1'b0, 32'h0);
        xfer1("rd20_h", 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'h5566ABEF);

        xfer1("err_oor", 32'h400, 1'b0, 3'd2, 32'h0, 1'b1, 32'h0);
        xfer1("err_mis", 32'h22, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0);
        xfer1("err_size", 32'h20, 1'b1, 3'd3, 32'hFFFFFFFF, 1'b1, 32'h0);
        xfer1("rd20_err", 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'h5566ABEF);

        // Non-transfers: IDLE and BUSY while selected, NONSEQ while not selected.
        hwdata = 32'hFFFFFFFF;
        hsel1  = 1'b1;
        drive_addr(32'h20, 2'b00, 1'b1, 3'd2);
        tick;
        chk1("nt_idle", hreadyout1, hresp1, hrdata1, 1'b1, 2'b00, 32'h0);
        htrans = 2'b01;
        tick;
        chk1("nt_busy", hreadyout1, hresp1, hrdata1, 1'b1, 2'b00, 32'h0);
        hsel1  = 1'b0;
        htrans = 2'b10;
        tick;
        chk1("nt_nosel", hreadyout1, hresp1, hrdata1, 1'b1, 2'b00, 32'h0);
        htrans = 2'b00;
        tick;
        chk1("nt_after", hreadyout1, hresp1, hrdata1, 1'b1, 2'b00, 32'h0);
        xfer1("rd20_nt", 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'h5566ABEF);

        // Zero-wait instance: four back-to-back pipelined transfers.
        hsel0 = 1'b1;
        drive_addr(32'h30, 2'b10, 1'b1, 3'd2);
        tick;
        hwdata = 32'h11111111;
        drive_addr(32'h30, 2'b10, 1'b0, 3'd2);
        chk1("p_wr30", hreadyout0, hresp0, hrdata0, 1'b1, 2'b00, 32'h0);
        tick;
        drive_addr(32'h31, 2'b10, 1'b1, 3'd0);
        chk1("p_rd30", hreadyout0, hresp0, hrdata0, 1'b1, 2'b00, 32'h11111111);
        tick;
        hwdata = 32'h00002200;
        drive_addr(32'h30, 2'b10, 1'b0, 3'd2);
        chk1("p_wrb31", hreadyout0, hresp0, hrdata0, 1'b1, 2'b00, 32'h0);
        tick;
        hsel0  = 1'b0;
        htrans = 2'b00;
        chk1("p_rd30_b", hreadyout0, hresp0, hrdata0, 1'b1, 2'b00, 32'h11112211);
        tick;
        chk1("p_idle", hreadyout0, hresp0, hrdata0, 1'b1, 2'b00, 32'h0);
        chk1("p_ws1_quiet", hreadyout1, hresp1, hrdata1, 1'b1, 2'b00, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
